dual_ch_trigger_capture: RTL and testbench
==========================================

Name: dual_ch_trigger_capture

Overview:
- Downstream consumer of the synchronised two-channel ADC samples (A2DA_DATA / A2DB_DATA, optionally gated by the prescaler's DATA_VALID).
- Arms on command and keeps a rolling pre-trigger history.
- Detects a rising level crossing on a selectable channel, or accepts a forced trigger, then fills the rest of a dual-channel circular buffer.
- When the capture is frozen, presents it for random-access readout in trigger-relative order with BUFFER_READY.

Parameters:
- DATA_W, 14, sample width in bits (two's complement).
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples per channel.
- PRETRIG, 256, samples retained before the trigger sample; legal range 1..DEPTH-1.

Ports:
- SYS_CLK  in  1  system clock (100 MHz PLL output); all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN_A  in  DATA_W  channel A sample, two's complement.
- DATA_IN_B  in  DATA_W  channel B sample, two's complement.
- DATA_VALID  in  1  sample-enable strobe; tie to 1 for full rate.
- ARM  in  1  single-cycle pulse that starts a capture.
- TRIG_SRC  in  1  trigger channel select: 0 = A, 1 = B.
- TRIG_LEVEL  in  DATA_W  signed trigger threshold.
- FORCE_TRIG  in  1  trigger immediately regardless of level.
- RD_ADDR  in  ADDR_W  logical read index; 0 = oldest sample, PRETRIG = trigger sample.
- RD_DATA_A  out  DATA_W  channel A readout.
- RD_DATA_B  out  DATA_W  channel B readout.
- BUFFER_READY  out  1  capture complete, buffer frozen.
- BUSY  out  1  high in PRE_FILL, WAIT_TRIG and POST_FILL.
- TRIGGERED_BY_FORCE  out  1  last capture was ended by FORCE_TRIG.

Behaviour:
- Reset: state = IDLE. BUFFER_READY, BUSY and TRIGGERED_BY_FORCE = 0. RD_DATA_A/B = 0. Write pointer wp = 0, counters = 0. Memory is not cleared. Reset mid-capture aborts to IDLE within one cycle.
- A sample is any cycle with DATA_VALID = 1 while state is PRE_FILL, WAIT_TRIG or POST_FILL.
  - Each sample writes A and B to mem[wp] together.
  - wp then increments modulo DEPTH (wrap-around is silent).
- States:
  - IDLE: nothing is written. ARM -> PRE_FILL, with wp and counters cleared, prev_valid cleared, BUFFER_READY = 0, TRIGGERED_BY_FORCE = 0.
  - PRE_FILL: count samples. After PRETRIG samples -> WAIT_TRIG. Crossings and FORCE_TRIG are ignored here.
  - WAIT_TRIG: samples keep overwriting the ring. A trigger condition on a valid sample:
    - that sample is the trigger sample and is written;
    - start = (wp - PRETRIG) mod DEPTH is latched, with wp taken before its increment;
    - post_cnt = 1;
    - state -> POST_FILL.
  - POST_FILL: each sample increments post_cnt. The sample that makes post_cnt = DEPTH-PRETRIG is written, then state -> DONE on the next cycle.
  - DONE: BUFFER_READY = 1, BUSY = 0, no writes. ARM -> PRE_FILL, with BUFFER_READY = 0 on the next cycle.
- ARM while BUSY is ignored.
- Trigger condition, evaluated only in WAIT_TRIG and only on a valid sample:
  - level crossing: prev_valid AND prev_sel < TRIG_LEVEL AND cur_sel >= TRIG_LEVEL, signed compare, where sel is the channel chosen by TRIG_SRC;
  - OR FORCE_TRIG = 1.
  - Tracking: prev_sel updates on every valid sample in PRE_FILL, WAIT_TRIG and POST_FILL. prev_valid is set after the first valid sample following ARM, so the first post-arm sample can never cause a level crossing.
  - If the crossing and FORCE_TRIG occur in the same cycle, it is one trigger and TRIGGERED_BY_FORCE = 1.
  - FORCE_TRIG with DATA_VALID = 0 is held pending and consumed by the next valid sample in WAIT_TRIG. The pending flag clears on trigger, ARM or RESET.
  - TRIG_SRC and TRIG_LEVEL are sampled every cycle; changing them mid-capture is legal.
- Readout:
  - RD_DATA_x <= mem_x[(start + RD_ADDR) mod DEPTH], registered, one-cycle latency, inferred as simple dual-port RAM.
  - Readout is meaningful only while BUFFER_READY = 1. Outside that window it returns memory contents, with no other side effects.
- No back-pressure: the block never stalls DATA_VALID. Samples arriving in IDLE or DONE are dropped.

Test Plan:
- Bench parameters for all scenarios: ADDR_W = 4 (DEPTH 16), PRETRIG = 4.
1. Ramp, basic level trigger:
   - Stimulus: RESET, ARM, DATA_VALID = 1, A = ramp -8, -7, … starting the cycle after ARM, TRIG_SRC = 0, TRIG_LEVEL = 0.
   - Required response: trigger on A = 0.
   - BUFFER_READY rises 12 samples after the trigger sample (the trigger sample plus 11 more), one cycle after the last write.
   - Reading RD_ADDR 0..15 returns A = -4..11; RD_ADDR 4 returns 0.
2. Crossing during PRE_FILL ignored:
   - Stimulus: A = -1, 5, 5, 5, then -3, then 2.
   - Required response: no trigger on the 5 (still PRE_FILL); trigger on 2.
   - Logical RD_ADDR 4 = 2; RD_ADDR 3 = -3.
3. FORCE_TRIG with DATA_VALID low:
   - Stimulus: A held at -100 (no crossing), FORCE_TRIG pulse while DATA_VALID = 0 in WAIT_TRIG, next valid sample A = -100.
   - Required response: that sample is the trigger; TRIGGERED_BY_FORCE = 1; BUFFER_READY after 11 further valid samples.
4. Channel B select with signed negative level:
   - Stimulus: TRIG_SRC = 1, TRIG_LEVEL = -50, B = -60 then -40, while A makes crossings of its own.
   - Required response: trigger on B = -40; A crossings are ignored.
5. Wrap-around:
   - Stimulus: 37 samples in WAIT_TRIG before the trigger, counter pattern on B.
   - Required response: RD_ADDR 0..15 returns 16 consecutive counter values, ending 11 after the trigger value.
6. Reset and re-arm:
   - Stimulus: RESET mid POST_FILL, then ARM while BUSY.
   - Required response: after RESET, BUSY = 0 and BUFFER_READY = 0 next cycle.
   - ARM while BUSY is ignored (no restart of PRE_FILL count).
   - ARM in DONE clears BUFFER_READY next cycle.

Source files
------------

// File: rtl/dual_ch_trigger_capture_if.sv
// Purpose: carries one ADC sample pair, trigger controls and buffer readout between a front end and the capture block.
// Latency: plain wires; the capture block answers reads one cycle after rd_addr.
// Backpressure: none; samples arrive on data_valid and are never stalled.
// Ports: master drives data_in_a/b, data_valid, arm, trig_src, trig_level, force_trig, rd_addr;
//        slave drives rd_data_a/b, buffer_ready, busy, triggered_by_force.
interface dual_ch_trigger_capture_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] data_in_a;
    logic [DATA_W-1:0] data_in_b;
    logic              data_valid;
    logic              arm;
    logic              trig_src;
    logic [DATA_W-1:0] trig_level;
    logic              force_trig;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              buffer_ready;
    logic              busy;
    logic              triggered_by_force;

    modport master (
        output data_in_a, data_in_b, data_valid, arm, trig_src, trig_level, force_trig, rd_addr,
        input  rd_data_a, rd_data_b, buffer_ready, busy, triggered_by_force
    );

    modport slave (
        input  data_in_a, data_in_b, data_valid, arm, trig_src, trig_level, force_trig, rd_addr,
        output rd_data_a, rd_data_b, buffer_ready, busy, triggered_by_force
    );
endinterface

// File: rtl/dual_ch_trigger_capture.sv
// Purpose: armed dual-channel capture with pre-trigger history, level/forced trigger, trigger-relative readout.
// Latency: sample written on its valid cycle; buffer_ready one cycle after the last write; readout one cycle after rd_addr.
// Backpressure: none; samples in IDLE/DONE are dropped, arm while busy is ignored.
// Ports: sys_clk_i, reset_i (sync, active high), cap_if (slave side of dual_ch_trigger_capture_if).
module dual_ch_trigger_capture #(
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 10,
    parameter int PRETRIG = 256
) (
    input  logic                       sys_clk_i,
    input  logic                       reset_i,
    dual_ch_trigger_capture_if.slave   cap_if
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_LEN  = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] POST_LEN = ADDR_W'(DEPTH - PRETRIG);

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST_FILL,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [DATA_W-1:0] prev_sel_q, prev_sel_d;
    logic              prev_valid_q, prev_valid_d;
    logic              force_pend_q, force_pend_d;
    logic              trig_force_q, trig_force_d;
    logic [DATA_W-1:0] rd_a_q, rd_b_q;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic              capturing;
    logic              smp_vld;
    logic [DATA_W-1:0] cur_sel;
    logic              crossing;
    logic              force_eff;
    logic              trig_hit;
    logic [ADDR_W-1:0] pre_inc;
    logic [ADDR_W-1:0] post_inc;
    logic [ADDR_W-1:0] rd_idx;

    assign capturing = (state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST_FILL);
    assign smp_vld   = capturing && cap_if.data_valid;
    assign cur_sel   = cap_if.trig_src ? cap_if.data_in_b : cap_if.data_in_a;

    // prev_valid_q keeps the first sample after arm from ever forming a crossing
    assign crossing  = prev_valid_q
                    && ($signed(prev_sel_q) <  $signed(cap_if.trig_level))
                    && ($signed(cur_sel)    >= $signed(cap_if.trig_level));
    assign force_eff = cap_if.force_trig || force_pend_q;
    assign trig_hit  = (state_q == WAIT_TRIG) && smp_vld && (crossing || force_eff);

    assign pre_inc   = pre_cnt_q + 1'b1;
    assign post_inc  = post_cnt_q + 1'b1;

    // logical index 0 is the oldest retained sample; ADDR_W arithmetic gives the ring wrap
    assign rd_idx    = start_q + cap_if.rd_addr;

    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        start_d      = start_q;
        prev_sel_d   = prev_sel_q;
        prev_valid_d = prev_valid_q;
        force_pend_d = force_pend_q;
        trig_force_d = trig_force_q;

        if (smp_vld) begin
            wp_d         = wp_q + 1'b1;
            prev_sel_d   = cur_sel;
            prev_valid_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (cap_if.arm) begin
                    state_d      = PRE_FILL;
                    wp_d         = '0;
                    pre_cnt_d    = '0;
                    post_cnt_d   = '0;
                    prev_valid_d = 1'b0;
                    force_pend_d = 1'b0;
                    trig_force_d = 1'b0;
                end
            end
            PRE_FILL: begin
                if (smp_vld) begin
                    pre_cnt_d = pre_inc;
                    if (pre_inc == PRE_LEN) begin
                        state_d = WAIT_TRIG;
                    end
                end
            end
            WAIT_TRIG: begin
                if (trig_hit) begin
                    // wp_q still points at the slot the trigger sample is written to
                    start_d      = wp_q - PRE_LEN;
                    post_cnt_d   = ADDR_W'(1);
                    trig_force_d = force_eff;
                    force_pend_d = 1'b0;
                    state_d      = (POST_LEN == ADDR_W'(1)) ? DONE : POST_FILL;
                end else if (cap_if.force_trig && !cap_if.data_valid) begin
                    // a force without a sample waits for the next valid sample
                    force_pend_d = 1'b1;
                end
            end
            POST_FILL: begin
                if (smp_vld) begin
                    post_cnt_d = post_inc;
                    if (post_inc == POST_LEN) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            wp_q         <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            start_q      <= '0;
            prev_sel_q   <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            trig_force_q <= 1'b0;
            rd_a_q       <= '0;
            rd_b_q       <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            start_q      <= start_d;
            prev_sel_q   <= prev_sel_d;
            prev_valid_q <= prev_valid_d;
            force_pend_q <= force_pend_d;
            trig_force_q <= trig_force_d;
            rd_a_q       <= mem_a[rd_idx];
            rd_b_q       <= mem_b[rd_idx];
        end
    end

    // sample storage: no reset so it maps onto simple dual-port RAM
    always_ff @(posedge sys_clk_i) begin
        if (smp_vld && !reset_i) begin
            mem_a[wp_q] <= cap_if.data_in_a;
            mem_b[wp_q] <= cap_if.data_in_b;
        end
    end

    assign cap_if.rd_data_a          = rd_a_q;
    assign cap_if.rd_data_b          = rd_b_q;
    assign cap_if.buffer_ready       = (state_q == DONE);
    assign cap_if.busy               = capturing;
    assign cap_if.triggered_by_force = trig_force_q;
endmodule

// File: tb/tb_dual_ch_trigger_capture.sv
// Purpose: self-checking bench for dual_ch_trigger_capture with DEPTH 16, PRETRIG 4.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives data_valid freely.
module tb_dual_ch_trigger_capture;
    localparam int DW    = 14;
    localparam int AW    = 4;
    localparam int PT    = 4;
    localparam int DEPTH = 16;
    localparam int POST  = DEPTH - PT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_ch_trigger_capture_if #(.DATA_W(DW), .ADDR_W(AW)) cif ();

    dual_ch_trigger_capture #(.DATA_W(DW), .ADDR_W(AW), .PRETRIG(PT)) dut (
        .sys_clk_i (clk),
        .reset_i   (rst),
        .cap_if    (cif)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit rst;
        bit arm;
        bit vld;
        bit frc;
        int a;
        bit e_busy;
        bit e_rdy;
        bit e_tbf;
    } vec_t;

    vec_t tbl[$];

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit r, input bit arm, input bit vld, input bit frc, input int a, input int b);
        rst                = r;
        cif.arm            = arm;
        cif.data_valid     = vld;
        cif.force_trig     = frc;
        cif.data_in_a      = DW'(a);
        cif.data_in_b      = DW'(b);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        cif.arm        = 1'b0;
        cif.data_valid = 1'b0;
        cif.force_trig = 1'b0;
    endtask

    task automatic samp(input int a, input int b);
        drive(1'b0, 1'b0, 1'b1, 1'b0, a, b);
    endtask

    task automatic read_chk(input string name, input int idx, input bit chb, input int exp);
        cif.rd_addr = AW'(idx);
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d]", name, idx), chb ? sx(cif.rd_data_b) : sx(cif.rd_data_a), exp);
    endtask

    task automatic add(input bit r, input bit arm, input bit vld, input bit frc, input int a,
                       input bit eb, input bit er, input bit et);
        vec_t v;
        v.rst = r; v.arm = arm; v.vld = vld; v.frc = frc; v.a = a;
        v.e_busy = eb; v.e_rdy = er; v.e_tbf = et;
        tbl.push_back(v);
    endtask

    // Reference model: the capture is the list of samples accepted since arm;
    // the trigger is an index into that list and the frozen buffer is a slice of it.
    task automatic run_random(input int r);
        int  qa[$];
        int  qb[$];
        int  trig;
        bit  pend;
        bit  tbf;
        bit  done;
        int  src;
        int  lvl;
        bit  vld;
        bit  frc;
        bit  arm;
        int  a;
        int  b;
        int  n;
        int  ps;
        int  cs;
        src  = int'($urandom_range(0, 1));
        lvl  = int'($urandom_range(0, 8)) - 4;
        cif.trig_src   = src[0];
        cif.trig_level = DW'(lvl);
        trig = -1;
        pend = 1'b0;
        tbf  = 1'b0;
        done = 1'b0;
        // the sample on the arm cycle itself is dropped
        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 7, 7);
        check($sformatf("rnd%0d arm busy", r), int'(cif.busy), 1);
        for (int c = 0; c < 500 && !done; c++) begin
            vld = ($urandom_range(0, 3) != 0);
            frc = ($urandom_range(0, 29) == 0);
            arm = ($urandom_range(0, 49) == 0);
            a   = int'($urandom_range(0, 16)) - 8;
            b   = int'($urandom_range(0, 16)) - 8;
            if (vld) begin
                qa.push_back(a);
                qb.push_back(b);
                n = qa.size() - 1;
                if (trig < 0) begin
                    if (n >= PT) begin
                        ps = src[0] ? qb[n-1] : qa[n-1];
                        cs = src[0] ? b : a;
                        if ((ps < lvl && cs >= lvl) || frc || pend) begin
                            trig = n;
                            tbf  = frc || pend;
                            pend = 1'b0;
                        end
                    end
                end else if (n == trig + POST - 1) begin
                    done = 1'b1;
                end
            end else if (frc && trig < 0 && qa.size() >= PT) begin
                pend = 1'b1;
            end
            drive(1'b0, arm, vld, frc, a, b);
            check($sformatf("rnd%0d c%0d busy", r, c), int'(cif.busy), int'(!done));
            check($sformatf("rnd%0d c%0d ready", r, c), int'(cif.buffer_ready), int'(done));
            check($sformatf("rnd%0d c%0d tbf", r, c), int'(cif.triggered_by_force), int'(tbf));
        end
        check($sformatf("rnd%0d finished in budget", r), int'(done), 1);
        if (done) begin
            for (int i = 0; i < DEPTH; i++) begin
                read_chk($sformatf("rnd%0d A", r), i, 1'b0, qa[trig - PT + i]);
                read_chk($sformatf("rnd%0d B", r), i, 1'b1, qb[trig - PT + i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        cif.arm        = 1'b0;
        cif.data_valid = 1'b0;
        cif.force_trig = 1'b0;
        cif.data_in_a  = '0;
        cif.data_in_b  = '0;
        cif.trig_src   = 1'b0;
        cif.trig_level = '0;
        cif.rd_addr    = '0;

        // forced trigger with data_valid low, then reset/re-arm corners; A stays at -100
        add(1, 0, 0, 0, 0,    0, 0, 0);
        add(0, 1, 0, 0, 0,    1, 0, 0);
        add(0, 0, 1, 0, -100, 1, 0, 0);
        add(0, 0, 1, 1, -100, 1, 0, 0);              // force in PRE_FILL is ignored
        add(0, 0, 1, 0, -100, 1, 0, 0);
        add(0, 0, 1, 0, -100, 1, 0, 0);
        add(0, 0, 1, 0, -100, 1, 0, 0);              // WAIT_TRIG, no crossing
        add(0, 0, 0, 1, -100, 1, 0, 0);              // force held pending
        add(0, 0, 1, 0, -100, 1, 0, 1);              // trigger sample
        for (int k = 1; k <= 11; k++) add(0, 0, 1, 0, -100, k < 11, k == 11, 1);
        add(0, 1, 0, 0, 0,    1, 0, 0);              // arm in DONE
        for (int k = 0; k < 4; k++) add(0, 0, 1, 0, -100, 1, 0, 0);
        add(0, 0, 1, 1, -100, 1, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 0, -100, 1, 0, 1);
        add(1, 0, 0, 0, 0,    0, 0, 0);              // reset mid POST_FILL
        add(0, 1, 0, 0, 0,    1, 0, 0);
        add(0, 0, 1, 0, -100, 1, 0, 0);
        add(0, 0, 1, 0, -100, 1, 0, 0);
        add(0, 1, 1, 0, -100, 1, 0, 0);              // arm while busy ignored
        add(0, 0, 1, 0, -100, 1, 0, 0);
        add(0, 0, 1, 1, -100, 1, 0, 1);              // still counted: now in WAIT_TRIG
        for (int k = 1; k <= 11; k++) add(0, 0, 1, 0, -100, k < 11, k == 11, 1);
        add(0, 1, 0, 0, 0,    1, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].arm, tbl[i].vld, tbl[i].frc, tbl[i].a, tbl[i].a);
            check($sformatf("vec%0d busy", i), int'(cif.busy), int'(tbl[i].e_busy));
            check($sformatf("vec%0d ready", i), int'(cif.buffer_ready), int'(tbl[i].e_rdy));
            check($sformatf("vec%0d tbf", i), int'(cif.triggered_by_force), int'(tbl[i].e_tbf));
        end

        // ramp with level trigger at 0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("rst rd_a", sx(cif.rd_data_a), 0);
        check("rst rd_b", sx(cif.rd_data_b), 0);
        check("rst busy", int'(cif.busy), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int v = -8; v <= 10; v++) samp(v, 0);
        check("ramp ready early", int'(cif.buffer_ready), 0);
        samp(11, 0);
        check("ramp ready", int'(cif.buffer_ready), 1);
        check("ramp busy", int'(cif.busy), 0);
        check("ramp tbf", int'(cif.triggered_by_force), 0);
        for (int i = 0; i < DEPTH; i++) read_chk("ramp A", i, 1'b0, i - 4);

        // crossing inside PRE_FILL is ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        samp(-1, 0); samp(5, 0); samp(5, 0); samp(5, 0); samp(-3, 0); samp(2, 0);
        for (int k = 0; k < 11; k++) samp(50, 0);
        check("prefill ready", int'(cif.buffer_ready), 1);
        read_chk("prefill A", 4, 1'b0, 2);
        read_chk("prefill A", 3, 1'b0, -3);
        read_chk("prefill A", 0, 1'b0, 5);

        // channel B with negative level; A crossings must not trigger
        cif.trig_src   = 1'b1;
        cif.trig_level = DW'(-50);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) samp(0, -60);
        samp(-60, -60); samp(-40, -60); samp(-60, -60); samp(-40, -60);
        samp(-60, -40);
        for (int k = 0; k < 10; k++) samp(-40, -40);
        check("chB ready early", int'(cif.buffer_ready), 0);
        samp(-40, -40);
        check("chB ready", int'(cif.buffer_ready), 1);
        read_chk("chB B", 4, 1'b1, -40);
        read_chk("chB B", 3, 1'b1, -60);
        read_chk("chB A", 4, 1'b0, -60);

        // wrap-around: 37 WAIT_TRIG samples before the trigger, counter on B
        cif.trig_src   = 1'b0;
        cif.trig_level = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k <= 40; k++) samp(-1, k);
        samp(0, 41);
        for (int k = 42; k <= 52; k++) samp(-1, k);
        check("wrap ready", int'(cif.buffer_ready), 1);
        for (int i = 0; i < DEPTH; i++) read_chk("wrap B", i, 1'b1, 37 + i);

        for (int r = 0; r < 8; r++) run_random(r);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
